// File: rtl/vend_pkg.sv
// Shared types for the vending machine front end: coin codes seen by the FSM
// and the per-channel debounce states.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_t;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_COUNT,
        DB_RELEASE
    } db_state_t;

    // Two simultaneous events are ambiguous and map to COIN_NONE.
    function automatic coin_t coin_code(input logic nickel, input logic dime);
        if (nickel && !dime) return COIN_5;
        if (dime && !nickel) return COIN_10;
        return COIN_NONE;
    endfunction

endpackage

// File: rtl/coin_acceptor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce FSM and counter.
// Emits a single-cycle registered evt per physical coin, however long the line stays high.
module coin_debounce
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sense,
    output logic evt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            s1, s2;
    db_state_t       state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            evt_next;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= DB_IDLE;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            s1    <= sense;
            s2    <= s1;
            state <= state_next;
            cnt   <= cnt_next;
            evt   <= evt_next;
        end
    end

    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        evt_next   = 1'b0;
        case (state)
            DB_IDLE: begin
                if (s2) begin
                    if (cnt == CNT_LAST) begin
                        state_next = DB_RELEASE;
                        evt_next   = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = DB_COUNT;
                        cnt_next   = cnt + CW'(1);
                    end
                end
            end
            DB_COUNT: begin
                if (!s2) begin
                    state_next = DB_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = DB_RELEASE;
                    evt_next   = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DB_RELEASE: begin
                // A high sample means the coin is still present: restart the low run.
                if (s2) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = DB_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = DB_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces nickel/dime sensors, queues coins, and issues them to the
// vending FSM as single-cycle codes separated by at least one idle cycle.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          nickel_sense,
    input  logic                          dime_sense,
    input  logic                          hold,
    output coin_t                         coin,
    output logic                          coin_return,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic          evt_n, evt_d;
    coin_t         mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    coin_t         push_code;
    logic          push_req, push, pop, full, reject;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nickel (
        .clk   (clk),
        .rst   (rst),
        .sense (nickel_sense),
        .evt   (evt_n)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dime (
        .clk   (clk),
        .rst   (rst),
        .sense (dime_sense),
        .evt   (evt_d)
    );

    // Extra pointer MSB distinguishes full from empty.
    assign pending = wr_ptr - rd_ptr;

    always_comb begin
        push_code = coin_code(evt_n, evt_d);
        push_req  = (push_code != COIN_NONE);
        full      = (pending == PW'(FIFO_DEPTH));
        // Issuing only while coin is idle spaces codes so the FSM leaves dispense first.
        pop       = (pending != '0) && !hold && (coin == COIN_NONE);
        push      = push_req && (!full || pop);
        reject    = (evt_n && evt_d) || (push_req && !push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            coin        <= COIN_NONE;
            coin_return <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            coin        <= pop ? mem[rd_ptr[AW-1:0]] : COIN_NONE;
            coin_return <= reject;
        end
    end

    // NOTE: storage has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_code;
    end

endmodule
